// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / LS) arbiter for one 64-bit memory port, one transaction in flight.
// Define YSYX_ARB_RR_EN for round-robin tie-breaking; default build is fixed LS-over-IF priority.
module mem_port_arbiter #(
    parameter int ADDR_W        = 64,
    parameter int DATA_W        = 64,
    parameter bit RESET_PRIO_LS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic [31:0]       if_inst,

    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [7:0]        ls_wmask,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;

    logic              grant_if, grant_ls, accept;

`ifdef YSYX_ARB_RR_EN
    owner_t last_grant_q;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        grant_ls = ls_req_valid && (!if_req_valid || (last_grant_q == OWN_IF));
        grant_if = if_req_valid && !grant_ls;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= RESET_PRIO_LS ? OWN_LS : OWN_IF;
        end else if (accept) begin
            last_grant_q <= grant_ls ? OWN_LS : OWN_IF;
        end
    end
`else
    logic unused_cfg;

    always_comb begin
        grant_ls = ls_req_valid;
        grant_if = if_req_valid && !ls_req_valid;
    end

    assign unused_cfg = RESET_PRIO_LS;
`endif

    assign accept       = (state_q == S_IDLE) && (grant_if || grant_ls);
    assign if_req_ready = (state_q == S_IDLE) && grant_if;
    assign ls_req_ready = (state_q == S_IDLE) && grant_ls;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)         state_d = S_REQ;
            S_REQ:   if (mem_req_ready)  state_d = S_RESP;
            S_RESP:  if (mem_resp_valid) state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Request fields are captured once at accept and held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= grant_ls ? OWN_LS : OWN_IF;
                addr_q  <= grant_ls ? ls_addr : if_addr;
                wen_q   <= grant_ls && ls_wen;
                wdata_q <= grant_ls ? ls_wdata : '0;
                wmask_q <= (grant_ls && ls_wen) ? ls_wmask : 8'h00;
            end
        end
    end

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    // Responses outside RESP are strays and never reach a requester.
    assign if_resp_valid = (state_q == S_RESP) && mem_resp_valid && (owner_q == OWN_IF);
    assign ls_resp_valid = (state_q == S_RESP) && mem_resp_valid && (owner_q == OWN_LS);

    assign if_rdata = mem_rdata;
    assign ls_rdata = mem_rdata;
    assign if_inst  = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];

    logic unused_addr;
    assign unused_addr = ^addr_q[1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, IF read, LS write, tie-break with backpressure,
// reset during RESP and stray responses.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_addr, if_rdata;
    logic [31:0] if_inst;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef YSYX_ARB_RR_EN
    localparam bit TIE_LS_FIRST = 1'b0;
`else
    localparam bit TIE_LS_FIRST = 1'b1;
`endif

    mem_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_resp_valid  (if_resp_valid),
        .if_rdata       (if_rdata),
        .if_inst        (if_inst),
        .ls_req_valid   (ls_req_valid),
        .ls_req_ready   (ls_req_ready),
        .ls_addr        (ls_addr),
        .ls_wen         (ls_wen),
        .ls_wdata       (ls_wdata),
        .ls_wmask       (ls_wmask),
        .ls_resp_valid  (ls_resp_valid),
        .ls_rdata       (ls_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        if_req_valid = 0; if_addr = '0;
        ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;

        // Reset state
        tick; tick;
        #1;
        chk("rst_if_ready",  if_req_ready,  0);
        chk("rst_ls_ready",  ls_req_ready,  0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_mem_addr",  mem_addr,      0);
        chk("rst_mem_wmask", mem_wmask,     0);
        chk("rst_if_resp",   if_resp_valid, 0);
        chk("rst_ls_resp",   ls_resp_valid, 0);
        rst = 1'b0;
        tick;

        // IF-only read with addr[2]=1
        if_req_valid = 1; if_addr = 64'h8000_0004; mem_req_ready = 1;
        #1;
        chk("if_ready_idle", if_req_ready, 1);
        chk("ls_ready_idle", ls_req_ready, 0);
        chk("mem_valid_idle", mem_req_valid, 0);
        tick;
        if_req_valid = 0; if_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("if_req_valid_req", mem_req_valid, 1);
        chk("if_mem_addr",   mem_addr,  64'h8000_0000);
        chk("if_mem_wmask",  mem_wmask, 0);
        chk("if_mem_wen",    mem_wen,   0);
        chk("if_ready_req",  if_req_ready, 0);
        tick;
        mem_resp_valid = 1; mem_rdata = 64'h1111_2222_3333_4444;
        #1;
        chk("if_resp_pulse", if_resp_valid, 1);
        chk("if_ls_resp",    ls_resp_valid, 0);
        chk("if_inst_hi",    if_inst, 32'h1111_2222);
        chk("if_rdata",      if_rdata, 64'h1111_2222_3333_4444);
        tick;
        mem_resp_valid = 0;
        #1;
        chk("if_resp_end",   if_resp_valid, 0);
        chk("if_mem_valid_end", mem_req_valid, 0);

        // LS write
        ls_req_valid = 1; ls_addr = 64'h8000_0010; ls_wen = 1; ls_wdata = 64'hAB; ls_wmask = 8'h01;
        #1;
        chk("lsw_ls_ready", ls_req_ready, 1);
        chk("lsw_if_ready", if_req_ready, 0);
        tick;
        ls_req_valid = 0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
        #1;
        chk("lsw_mem_valid", mem_req_valid, 1);
        chk("lsw_mem_addr",  mem_addr,  64'h8000_0010);
        chk("lsw_mem_wen",   mem_wen,   1);
        chk("lsw_mem_wdata", mem_wdata, 64'hAB);
        chk("lsw_mem_wmask", mem_wmask, 8'h01);
        tick;
        mem_resp_valid = 1; mem_rdata = 64'h0;
        #1;
        chk("lsw_ls_resp", ls_resp_valid, 1);
        chk("lsw_if_resp", if_resp_valid, 0);
        tick;
        mem_resp_valid = 0;

        // Tie in IDLE (LS is a read carrying a nonzero mask), then memory backpressure
        if_req_valid = 1; if_addr = 64'h8000_0008;
        ls_req_valid = 1; ls_addr = 64'h0000_0100; ls_wen = 0; ls_wmask = 8'hFF;
        mem_req_ready = 0;
        #1;
        chk("tie_ls_ready", ls_req_ready, TIE_LS_FIRST);
        chk("tie_if_ready", if_req_ready, !TIE_LS_FIRST);
        tick;
        if (TIE_LS_FIRST) ls_req_valid = 0; else if_req_valid = 0;
        for (int i = 0; i < 5; i++) begin
            mem_resp_valid = (i == 2);
            mem_rdata = 64'h5555_6666_7777_8888;
            #1;
            chk("bp_mem_valid", mem_req_valid, 1);
            chk("bp_mem_addr",  mem_addr, TIE_LS_FIRST ? 64'h100 : 64'h8000_0008);
            chk("bp_mem_wmask", mem_wmask, 0);
            chk("bp_if_ready",  if_req_ready, 0);
            chk("bp_ls_ready",  ls_req_ready, 0);
            chk("bp_if_resp",   if_resp_valid, 0);
            chk("bp_ls_resp",   ls_resp_valid, 0);
            tick;
        end
        mem_resp_valid = 0; mem_req_ready = 1;
        tick;
        mem_req_ready = 0;
        #1;
        chk("tie_resp_wait_valid", mem_req_valid, 0);
        chk("tie_resp_wait_resp",  if_resp_valid | ls_resp_valid, 0);
        tick;
        mem_resp_valid = 1;
        #1;
        chk("tie_w_ls_resp", ls_resp_valid, TIE_LS_FIRST);
        chk("tie_w_if_resp", if_resp_valid, !TIE_LS_FIRST);
        chk("tie_loser_blocked", TIE_LS_FIRST ? if_req_ready : ls_req_ready, 0);
        tick;
        mem_resp_valid = 0;
        #1;
        chk("tie_loser_ready", TIE_LS_FIRST ? if_req_ready : ls_req_ready, 1);
        tick;
        if_req_valid = 0; ls_req_valid = 0; ls_wmask = '0; mem_req_ready = 1;
        #1;
        chk("tie_loser_addr", mem_addr, TIE_LS_FIRST ? 64'h8000_0008 : 64'h100);
        tick;
        mem_resp_valid = 1;
        #1;
        chk("tie_l_ls_resp", ls_resp_valid, !TIE_LS_FIRST);
        chk("tie_l_if_resp", if_resp_valid, TIE_LS_FIRST);
        tick;
        mem_resp_valid = 0;

        // Reset while in RESP, then in-flight response arrives
        if_req_valid = 1; if_addr = 64'h8000_0004;
        tick;
        if_req_valid = 0;
        tick;
        #1;
        chk("rr_in_resp_valid", mem_req_valid, 0);
        rst = 1;
        #1;
        chk("rr_mem_valid", mem_req_valid, 0);
        chk("rr_mem_addr",  mem_addr, 0);
        chk("rr_if_ready",  if_req_ready, 0);
        mem_resp_valid = 1; mem_rdata = 64'h9999_9999_9999_9999;
        #1;
        chk("rr_if_resp",  if_resp_valid, 0);
        chk("rr_ls_resp",  ls_resp_valid, 0);
        tick;
        rst = 0;
        #1;
        chk("stray_if_resp", if_resp_valid, 0);
        chk("stray_ls_resp", ls_resp_valid, 0);
        tick;
        #1;
        chk("stray2_resp", if_resp_valid | ls_resp_valid, 0);
        chk("stray2_mem_valid", mem_req_valid, 0);
        mem_resp_valid = 0;

        // Normal IF read after reset, addr[2]=0 selects low half
        if_req_valid = 1; if_addr = 64'h8000_0020;
        #1;
        chk("post_if_ready", if_req_ready, 1);
        tick;
        if_req_valid = 0;
        #1;
        chk("post_mem_addr", mem_addr, 64'h8000_0020);
        tick;
        mem_resp_valid = 1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        #1;
        chk("post_if_resp", if_resp_valid, 1);
        chk("post_if_inst", if_inst, 32'hCAFE_F00D);
        tick;
        mem_resp_valid = 0;
        #1;
        chk("post_if_resp_end", if_resp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
